// File: rtl/icache_tag_ctrl_if.sv
// rtl/icache_tag_ctrl_if.sv - fetch/refill/flush handshake bundle for icache_tag_ctrl
interface icache_tag_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_hit;
  logic                  fill_valid;
  logic                  fill_ready;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  flush_req;

  // Fetch unit / refill engine side
  modport master (
    output req_valid, req_addr, fill_valid, fill_addr, flush_req,
    input  req_ready, rsp_valid, rsp_hit, fill_ready
  );

  // Tag controller side
  modport slave (
    input  req_valid, req_addr, fill_valid, fill_addr, flush_req,
    output req_ready, rsp_valid, rsp_hit, fill_ready
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - icache tag RAM sequencer: clear sweep, lookup, refill write, hit/miss stats; option macro ICACHE_TAG_BYPASS_EN
module icache_tag_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH   = 20,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_tag_ctrl_if.slave       bus,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   hit_cnt_o,
  output logic [CNT_WIDTH-1:0]   miss_cnt_o,
  output logic                   tag_wr_en_o,
  output logic [INDEX_WIDTH-1:0] tag_wr_addr_o,
  output logic [TAG_WIDTH:0]     tag_wr_data_o,
  output logic [INDEX_WIDTH-1:0] tag_rd_addr_o,
  input  logic [TAG_WIDTH:0]     tag_rd_data_i
);

  // Address layout: {tag, index, line offset}
  localparam int OFF_WIDTH = ADDR_WIDTH - TAG_WIDTH - INDEX_WIDTH;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                   pend_v_q, pend_v_d;
  logic [TAG_WIDTH-1:0]   pend_tag_q, pend_tag_d;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
`ifdef ICACHE_TAG_BYPASS_EN
  logic                   byp_v_q, byp_v_d;
  logic [TAG_WIDTH-1:0]   byp_tag_q, byp_tag_d;
`endif

  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  logic                   run;
  logic                   req_ready;
  logic                   req_fire, fill_fire;
  logic                   flush_run;
  logic [TAG_WIDTH:0]     cmp_word;
  logic                   rsp_hit;
  logic                   unused_offset;

  assign req_tag  = bus.req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx  = bus.req_addr[OFF_WIDTH +: INDEX_WIDTH];
  assign fill_tag = bus.fill_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign fill_idx = bus.fill_addr[OFF_WIDTH +: INDEX_WIDTH];

  // Line offset bits play no part in tag lookup
  assign unused_offset = ^{bus.req_addr[OFF_WIDTH-1:0], bus.fill_addr[OFF_WIDTH-1:0]};

  assign run = (state_q == ST_RUN);

`ifdef ICACHE_TAG_BYPASS_EN
  // Same-cycle read/write collisions are resolved by the bypass path
  assign req_ready = run;
`else
  // Fill has priority so the RAM never sees a same-cycle read and write
  assign req_ready = run & ~bus.fill_valid;
`endif

  assign req_fire  = bus.req_valid & req_ready;
  assign fill_fire = bus.fill_valid & run;
  assign flush_run = bus.flush_req & run;

  assign bus.req_ready  = req_ready;
  assign bus.fill_ready = run;
  assign bus.rsp_valid  = pend_v_q;
  assign bus.rsp_hit    = rsp_hit;
  assign busy_o         = ~run;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

  // Read address follows the request address whether or not a lookup fires
  assign tag_rd_addr_o = req_idx;

  // Tag RAM write port: zero every set while sweeping, refill tags while running
  always_comb begin
    tag_wr_en_o   = 1'b0;
    tag_wr_addr_o = fill_idx;
    tag_wr_data_o = {1'b1, fill_tag};
    if (!run) begin
      tag_wr_en_o   = 1'b1;
      tag_wr_addr_o = sweep_cnt_q;
      tag_wr_data_o = '0;
    end else if (fill_fire) begin
      tag_wr_en_o = 1'b1;
    end
  end

  // Hit decision for the lookup accepted on the previous edge
  always_comb begin
`ifdef ICACHE_TAG_BYPASS_EN
    cmp_word = byp_v_q ? {1'b1, byp_tag_q} : tag_rd_data_i;
`else
    cmp_word = tag_rd_data_i;
`endif
    rsp_hit = pend_v_q & cmp_word[TAG_WIDTH] & (cmp_word[TAG_WIDTH-1:0] == pend_tag_q);
  end

  // Next-state: sweep sequencing, pending lookup capture, saturating stats
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    pend_v_d    = req_fire;
    pend_tag_d  = req_fire ? req_tag : pend_tag_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`ifdef ICACHE_TAG_BYPASS_EN
    byp_v_d     = req_fire & fill_fire & (fill_idx == req_idx);
    byp_tag_d   = req_fire ? fill_tag : byp_tag_q;
`endif

    case (state_q)
      ST_SWEEP: begin
        if (bus.flush_req) begin
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == {INDEX_WIDTH{1'b1}}) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush_req) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_SWEEP;
        sweep_cnt_d = '0;
      end
    endcase

    if (pend_v_q) begin
      if (rsp_hit) begin
        if (hit_cnt_q != {CNT_WIDTH{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != {CNT_WIDTH{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end

    // A flush while running restarts the statistics window
    if (flush_run) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  // State and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
      pend_v_q    <= 1'b0;
      pend_tag_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`ifdef ICACHE_TAG_BYPASS_EN
      byp_v_q     <= 1'b0;
      byp_tag_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      pend_v_q    <= pend_v_d;
      pend_tag_q  <= pend_tag_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`ifdef ICACHE_TAG_BYPASS_EN
      byp_v_q     <= byp_v_d;
      byp_tag_q   <= byp_tag_d;
`endif
    end
  end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - directed self-checking bench for icache_tag_ctrl with a behavioural tag RAM
module tb_icache_tag_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_tag_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  logic        busy;
  logic [15:0] hit_cnt, miss_cnt;
  logic        tag_wr_en;
  logic [7:0]  tag_wr_addr;
  logic [20:0] tag_wr_data;
  logic [7:0]  tag_rd_addr;
  logic [20:0] tag_rd_data;

  // Power-up contents look like valid tag 0 everywhere so a missing sweep shows up as hits
  logic [20:0] mem [256] = '{default: 21'h100000};

  int pass_cnt  = 0;
  int total_cnt = 0;

  icache_tag_ctrl #(
    .ADDR_WIDTH (32),
    .INDEX_WIDTH(8),
    .TAG_WIDTH  (20),
    .CNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy_o       (busy),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt),
    .tag_wr_en_o  (tag_wr_en),
    .tag_wr_addr_o(tag_wr_addr),
    .tag_wr_data_o(tag_wr_data),
    .tag_rd_addr_o(tag_rd_addr),
    .tag_rd_data_i(tag_rd_data)
  );

  // Simple dual-port tag RAM, read-first, one cycle read latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_rd_data <= '0;
    end else begin
      if (tag_wr_en) mem[tag_wr_addr] <= tag_wr_data;
      tag_rd_data <= mem[tag_rd_addr];
    end
  end

  task automatic test_reset();
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.flush_req  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b00) $display("FAIL reset_rsp: got %b exp 00", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
    total_cnt++;
    if ({hit_cnt, miss_cnt} !== 32'h0) $display("FAIL reset_counters: got hit=%h miss=%h exp 0/0", hit_cnt, miss_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({busy, bus.req_ready, bus.fill_ready, tag_wr_en} !== 4'b1001)
      $display("FAIL reset_ctrl: got busy/req_ready/fill_ready/wr_en=%b exp 1001", {busy, bus.req_ready, bus.fill_ready, tag_wr_en});
    else pass_cnt++;
    total_cnt++;
    if (tag_wr_addr !== 8'h00 || tag_wr_data !== 21'h0) $display("FAIL reset_wr: got addr=%h data=%h exp 00/0", tag_wr_addr, tag_wr_data);
    else pass_cnt++;
  endtask

  task automatic test_sweep_first_lookup();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0000;
    for (int k = 0; k < 256; k++) begin
      #1;
      total_cnt++;
      if ({busy, tag_wr_en, bus.req_ready, bus.fill_ready, bus.rsp_valid} !== 5'b11000 || tag_wr_addr !== 8'(k) || tag_wr_data !== 21'h0)
        $display("FAIL sweep_cycle_%0d: got busy/wr_en/req_ready/fill_ready/rsp_valid=%b addr=%h data=%h exp 11000 addr=%h data=0",
                 k, {busy, tag_wr_en, bus.req_ready, bus.fill_ready, bus.rsp_valid}, tag_wr_addr, tag_wr_data, 8'(k));
      else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total_cnt++;
    if ({busy, bus.req_ready, bus.fill_ready, tag_wr_en} !== 4'b0110)
      $display("FAIL run_entry: got busy/req_ready/fill_ready/wr_en=%b exp 0110", {busy, bus.req_ready, bus.fill_ready, tag_wr_en});
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b10) $display("FAIL first_lookup_rsp: got valid/hit=%b exp 10", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd1)
      $display("FAIL first_lookup_cnt: got valid=%b hit=%0d miss=%0d exp 0/0/1", bus.rsp_valid, hit_cnt, miss_cnt);
    else pass_cnt++;
  endtask

  task automatic test_fill_hit();
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h0001_2340;
    #1;
    total_cnt++;
    if (tag_wr_en !== 1'b1 || tag_wr_addr !== 8'h34 || tag_wr_data !== 21'h100012)
      $display("FAIL fill_write: got en=%b addr=%h data=%h exp 1/34/100012", tag_wr_en, tag_wr_addr, tag_wr_data);
    else pass_cnt++;
`ifndef ICACHE_TAG_BYPASS_EN
    total_cnt++;
    if (bus.req_ready !== 1'b0) $display("FAIL fill_blocks_req: got req_ready=%b exp 0", bus.req_ready);
    else pass_cnt++;
`endif
    @(negedge clk);
    bus.fill_valid = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0001_234C;
    @(negedge clk);
    bus.req_addr = 32'h0002_2340;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b11) $display("FAIL fill_then_hit: got valid/hit=%b exp 11", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b10 || hit_cnt !== 16'd1)
      $display("FAIL tag_mismatch: got valid/hit=%b hit_cnt=%0d exp 10/1", {bus.rsp_valid, bus.rsp_hit}, hit_cnt);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd2 || bus.rsp_valid !== 1'b0)
      $display("FAIL fill_hit_cnt: got hit=%0d miss=%0d valid=%b exp 1/2/0", hit_cnt, miss_cnt, bus.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h0003_4560;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0003_4560;
    #1;
`ifdef ICACHE_TAG_BYPASS_EN
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL same_cycle_ready: got %b exp 1", bus.req_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.fill_valid = 1'b0;
    bus.req_valid  = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b11) $display("FAIL same_cycle_bypass_hit: got valid/hit=%b exp 11", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
`else
    total_cnt++;
    if (bus.req_ready !== 1'b0) $display("FAIL same_cycle_ready: got %b exp 0", bus.req_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.fill_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL same_cycle_stall: got rsp_valid=%b req_ready=%b exp 0/1", bus.rsp_valid, bus.req_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b11) $display("FAIL same_cycle_retry_hit: got valid/hit=%b exp 11", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
`endif
    @(negedge clk);
    #1;
    total_cnt++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2) $display("FAIL same_cycle_cnt: got hit=%0d miss=%0d exp 2/2", hit_cnt, miss_cnt);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h000A_B100;
    @(negedge clk);
    bus.fill_valid = 1'b0;
    bus.flush_req  = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_pre_busy: got %b exp 0", busy);
    else pass_cnt++;
    @(negedge clk);
    bus.flush_req = 1'b0;
    #1;
    total_cnt++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) $display("FAIL flush_clears_cnt: got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt);
    else pass_cnt++;
    for (int k = 0; k < 256; k++) begin
      #1;
      total_cnt++;
      if (busy !== 1'b1 || tag_wr_en !== 1'b1 || tag_wr_addr !== 8'(k) || tag_wr_data !== 21'h0)
        $display("FAIL flush_sweep_%0d: got busy=%b en=%b addr=%h data=%h exp 1/1/%h/0", k, busy, tag_wr_en, tag_wr_addr, tag_wr_data, 8'(k));
      else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_done_busy: got %b exp 0", busy);
    else pass_cnt++;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h000A_B100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b10) $display("FAIL flush_invalidates: got valid/hit=%b exp 10", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd1) $display("FAIL flush_post_cnt: got hit=%0d miss=%0d exp 0/1", hit_cnt, miss_cnt);
    else pass_cnt++;
  endtask

  task automatic test_flush_in_sweep();
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b1 || tag_wr_addr !== 8'd100) $display("FAIL sweep_mid: got busy=%b addr=%0d exp 1/100", busy, tag_wr_addr);
    else pass_cnt++;
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    for (int k = 0; k < 256; k++) begin
      #1;
      total_cnt++;
      if (busy !== 1'b1 || tag_wr_addr !== 8'(k))
        $display("FAIL restart_sweep_%0d: got busy=%b addr=%h exp 1/%h", k, busy, tag_wr_addr, 8'(k));
      else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total_cnt++;
    if (busy !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0)
      $display("FAIL restart_done: got busy=%b hit=%0d miss=%0d exp 0/0/0", busy, hit_cnt, miss_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h0007_7770;
    @(negedge clk);
    bus.fill_valid = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0007_7770;
    repeat (65534) @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (hit_cnt !== 16'hFFFE || miss_cnt !== 16'd0) $display("FAIL sat_prime: got hit=%h miss=%h exp fffe/0", hit_cnt, miss_cnt);
    else pass_cnt++;
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b11 || hit_cnt !== 16'hFFFF)
      $display("FAIL sat_mid: got valid/hit=%b hit=%h exp 11/ffff", {bus.rsp_valid, bus.rsp_hit}, hit_cnt);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd0) $display("FAIL sat_hold: got hit=%h miss=%h exp ffff/0", hit_cnt, miss_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0007_7770;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b11) $display("FAIL pre_reset_rsp: got valid/hit=%b exp 11", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit, busy, tag_wr_en} !== 4'b0011 || tag_wr_addr !== 8'h00 || hit_cnt !== 16'd0)
      $display("FAIL async_reset_lookup: got valid/hit/busy/en=%b addr=%h hit=%h exp 0011/00/0",
               {bus.rsp_valid, bus.rsp_hit, busy, tag_wr_en}, tag_wr_addr, hit_cnt);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    total_cnt++;
    if (tag_wr_addr !== 8'd10 || busy !== 1'b1) $display("FAIL sweep_before_reset: got addr=%0d busy=%b exp 10/1", tag_wr_addr, busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (tag_wr_addr !== 8'd0) $display("FAIL async_reset_sweep: got addr=%0d exp 0", tag_wr_addr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      #1;
      total_cnt++;
      if (busy !== 1'b1 || tag_wr_addr !== 8'(k))
        $display("FAIL reset_resweep_%0d: got busy=%b addr=%h exp 1/%h", k, busy, tag_wr_addr, 8'(k));
      else pass_cnt++;
      @(negedge clk);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0007_7770;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_hit} !== 2'b10) $display("FAIL reset_invalidates: got valid/hit=%b exp 10", {bus.rsp_valid, bus.rsp_hit});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sweep_first_lookup();
    test_fill_hit();
    test_same_cycle();
    test_flush();
    test_flush_in_sweep();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Sequencing controller for the 256-entry × 21-bit instruction-cache tag RAM (ICACHE_TAG0, simple dual-port, 1-cycle unregistered read). It clears all tags after reset or on flush, accepts fetch lookups, and returns hit/miss one cycle later. It also writes refill tags and keeps saturating hit/miss statistics. It sits between the fetch unit / refill engine and the tag RAM instance.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width; tag = addr[31:12], index = addr[11:4], line offset = addr[3:0]
- INDEX_WIDTH, 8, tag RAM address width (256 sets)
- TAG_WIDTH, 20, stored tag width; RAM word = {valid, tag} = 21 bits
- CNT_WIDTH, 16, statistics counter width

Ports:
- clk  in  1  single clock for the block and the tag RAM (drives both wr_clk and rd_clk of the RAM)
- rst  in  1  asynchronous, active-high reset; also drives RAM wr_rst/rd_rst
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when req_valid & req_ready
- req_addr  in  ADDR_WIDTH  fetch address
- rsp_valid  out  1  lookup result valid (no backpressure)
- rsp_hit  out  1  1 = valid tag match
- fill_valid  in  1  refill tag write request
- fill_ready  out  1  fill accepted when fill_valid & fill_ready
- fill_addr  in  ADDR_WIDTH  refilled line address
- flush_req  in  1  single-cycle pulse: invalidate all entries
- busy  out  1  sweep in progress
- hit_cnt  out  CNT_WIDTH  saturating hit count
- miss_cnt  out  CNT_WIDTH  saturating miss count
- tag_wr_en  out  1  RAM write enable
- tag_wr_addr  out  INDEX_WIDTH  RAM write address
- tag_wr_data  out  TAG_WIDTH+1  RAM write data {valid, tag}
- tag_rd_addr  out  INDEX_WIDTH  RAM read address
- tag_rd_data  in  TAG_WIDTH+1  RAM read data, valid 1 cycle after tag_rd_addr

## Operation
- States: SWEEP and RUN. Reset state is SWEEP with sweep_cnt = 0.
- SWEEP: tag_wr_en = 1, tag_wr_addr = sweep_cnt, tag_wr_data = 0.
  - sweep_cnt increments each cycle. At sweep_cnt == 255 the next state is RUN, so the sweep takes exactly 256 cycles.
  - req_ready = 0, fill_ready = 0, busy = 1.
- RUN: req_ready = 1 (subject to Configuration), fill_ready = 1, busy = 0.
- Fill fire: same cycle, tag_wr_en = 1, tag_wr_addr = fill_addr[11:4], tag_wr_data = {1, fill_addr[31:12]}.
- Lookup fire:
  - tag_rd_addr = req_addr[11:4] combinationally.
  - req_addr[31:12] is registered as pend_tag, together with pend_idx and pend_v.
  - Next cycle: rsp_valid = 1, rsp_hit = tag_rd_data[20] & (tag_rd_data[19:0] == pend_tag).
  - tag_rd_addr is don't-care when there is no lookup; drive req_addr[11:4].
- flush_req in RUN: next state is SWEEP with sweep_cnt = 0, and hit_cnt/miss_cnt clear. A lookup or fill firing in the same cycle as the flush still completes normally.
- flush_req in SWEEP: sweep restarts at sweep_cnt = 0.
- Counters: on each rsp_valid, increment hit_cnt if rsp_hit, else miss_cnt. Both hold at all-ones (saturate).

## Timing
- Reset values:
  - Registered outputs: rsp_valid = 0, rsp_hit = 0, hit_cnt = 0, miss_cnt = 0.
  - Combinational outputs during and after reset: busy = 1, req_ready = 0, fill_ready = 0, tag_wr_en = 1, tag_wr_addr = 0, tag_wr_data = 0.
- First cycle RUN is possible: 256 rising edges after rst deasserts.
- Lookup latency: accept at edge N, rsp_valid high for exactly the cycle after edge N; sustains 1 lookup/cycle.
- A fill at edge N is visible to a lookup accepted at edge N+1 or later through the RAM.
- Same-cycle fill and lookup to the same index: handling is set by the Configuration macro.
- rsp_valid never asserts in response to a cycle where req_ready = 0.

## Configuration
- ICACHE_TAG_BYPASS_EN defined:
  - req_ready stays 1 in RUN, regardless of fill activity.
  - If fill fires in the same cycle as a lookup with equal index, the fill tag is registered with a bypass flag.
  - The response then compares against {1, fill tag} instead of tag_rd_data.
- ICACHE_TAG_BYPASS_EN undefined: req_ready = 0 whenever fill_valid = 1 in RUN (fill wins), so no same-cycle read/write to the tag RAM ever occurs.

## Test plan
- Reset release, then hold req_valid = 1 -> busy = 1 and tag_wr_en = 1 for 256 cycles with tag_wr_addr 0..255, data 0. First accept on cycle 257; rsp_hit = 0, miss_cnt = 1.
- Fill 0x0001_2340, then lookup 0x0001_234C two cycles later -> rsp_hit = 1, hit_cnt = 1. Lookup 0x0002_2340 -> rsp_hit = 0 (same index 0x34, tag mismatch).
- Fill and lookup 0x0001_2340 in the same cycle:
  - With ICACHE_TAG_BYPASS_EN: rsp_hit = 1 next cycle.
  - Without it: req_ready = 0 that cycle, and the lookup accepted one cycle later returns rsp_hit = 1.
- Fill index 0x10, then flush_req -> counters reset to 0 and busy = 1 for 256 cycles. A lookup to the same address afterwards returns rsp_hit = 0.
- flush_req pulsed at sweep_cnt = 100 -> sweep restarts at 0; busy stays high 256 cycles after the second pulse.
- Force hit_cnt to 0xFFFE, then issue 3 hits -> hit_cnt stays 0xFFFF and miss_cnt is unchanged.
- Assert rst mid-sweep and mid-lookup -> rsp_valid drops to 0 immediately and the sweep restarts at 0 after release.
